cache_fill_arbiter: RTL and testbench

Shared-memory miss handler between the I-cache/D-cache and the multi-cycle main memory (memory4c). Arbitrates I-cache misses, D-cache misses and D-cache write-through stores onto the single memory port. For each miss it streams one full 16-byte block (8 words) into the requesting cache, then issues a one-cycle tag/valid write. Replaces the ad-hoc address/enable muxing at the cpu top level.

---
 rtl/cache_fill_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Shares the single multi-cycle memory port between I-cache misses,
//   D-cache misses and D-cache write-through stores. A miss streams a full
//   8-word block into the owning cache and then pulses that cache's
//   tag/valid write for one cycle.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   icache_miss/_addr              I-cache miss request and byte address
//   dcache_miss/_addr              D-cache miss request and byte address
//   dcache_wr_req/_addr/_data      write-through store
//   mem_data_out, mem_data_valid   memory read return
//   mem_addr, mem_enable, mem_wr,
//   mem_data_in                    memory request port
//   fill_data, fill_word_idx       word written into the owner's data array
//   icache_fill_we, dcache_fill_we data-array write enables
//   icache_tag_we, dcache_tag_we   tag/valid write at fill end
//   icache_busy, dcache_busy       fill in progress for that cache
//   dcache_wr_ack                  store performed this cycle
module cache_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_miss,
    input  logic [15:0] icache_miss_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_miss_addr,
    input  logic        dcache_wr_req,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word_idx,
    output logic        icache_fill_we,
    output logic        dcache_fill_we,
    output logic        icache_tag_we,
    output logic        dcache_tag_we,
    output logic        icache_busy,
    output logic        dcache_busy,
    output logic        dcache_wr_ack
);

    localparam logic [3:0] BLOCK_WORDS = 4'(WORDS_PER_BLOCK);
    localparam logic [3:0] LAST_WORD   = 4'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;        // 0 = I-cache, 1 = D-cache
    logic [11:0] base_q, base_d;          // block address, addr[15:4]
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  recv_cnt_q, recv_cnt_d;

    // Read data goes straight to both caches; only the write enables select.
    assign fill_data = mem_data_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        base_d         = base_q;
        issue_cnt_d    = issue_cnt_q;
        recv_cnt_d     = recv_cnt_q;
        mem_addr       = '0;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_data_in    = '0;
        fill_word_idx  = '0;
        icache_fill_we = 1'b0;
        dcache_fill_we = 1'b0;
        icache_tag_we  = 1'b0;
        dcache_tag_we  = 1'b0;
        icache_busy    = 1'b0;
        dcache_busy    = 1'b0;
        dcache_wr_ack  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The latching cycle issues no request; the first read goes
                // out in the first FILL cycle.
                if (icache_miss) begin
                    owner_d     = 1'b0;
                    base_d      = icache_miss_addr[15:4];
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end else if (dcache_miss) begin
                    owner_d     = 1'b1;
                    base_d      = dcache_miss_addr[15:4];
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end else if (dcache_wr_req) begin
                    mem_enable    = 1'b1;
                    mem_wr        = 1'b1;
                    mem_addr      = dcache_wr_addr;
                    mem_data_in   = dcache_wr_data;
                    dcache_wr_ack = 1'b1;
                end
            end
            FILL: begin
                icache_busy = ~owner_q;
                dcache_busy = owner_q;
                // Requests are pipelined back to back; returns are counted
                // independently so memory latency can vary per request.
                if (issue_cnt_q < BLOCK_WORDS) begin
                    mem_enable  = 1'b1;
                    mem_addr    = {base_q, issue_cnt_q[2:0], 1'b0};
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid) begin
                    icache_fill_we = ~owner_q;
                    dcache_fill_we = owner_q;
                    fill_word_idx  = recv_cnt_q[2:0];
                    recv_cnt_d     = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                icache_busy   = ~owner_q;
                dcache_busy   = owner_q;
                icache_tag_we = ~owner_q;
                dcache_tag_we = owner_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Hold every request/enable low while reset is asserted so a store
        // or miss presented during reset cannot reach memory or the caches.
        if (!rst_n) begin
            mem_addr       = '0;
            mem_enable     = 1'b0;
            mem_wr         = 1'b0;
            mem_data_in    = '0;
            fill_word_idx  = '0;
            icache_fill_we = 1'b0;
            dcache_fill_we = 1'b0;
            icache_tag_we  = 1'b0;
            dcache_tag_we  = 1'b0;
            icache_busy    = 1'b0;
            dcache_busy    = 1'b0;
            dcache_wr_ack  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

    localparam int MEM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        dcache_wr_req;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        icache_fill_we, dcache_fill_we;
    logic        icache_tag_we, dcache_tag_we;
    logic        icache_busy, dcache_busy;
    logic        dcache_wr_ack;

    cache_fill_arbiter #(.WORDS_PER_BLOCK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_in(mem_data_in), .fill_data(fill_data),
        .fill_word_idx(fill_word_idx),
        .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
        .icache_tag_we(icache_tag_we), .dcache_tag_we(dcache_tag_we),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy),
        .dcache_wr_ack(dcache_wr_ack)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        logic        owner;
        logic [2:0]  idx;
        logic [15:0] data;
    } fill_t;

    rsp_t        memq[$];
    fill_t       fillq[$];
    logic [15:0] addrq[$];
    int          cyc = 0;
    int          last_due = 0;
    bit          irregular = 1'b0;
    bit          stray = 1'b0;
    logic [15:0] mem_base_data = 16'hA000;

    // Word k of a block reads as base + k; the top address bit is folded in
    // so the I and D blocks of one test return distinguishable data.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem_base_data + {a[15], 12'b0, a[3:1]};
    endfunction

    always @(negedge clk) begin
        if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
            int lat;
            int due;
            rsp_t r;
            lat = irregular ? int'($urandom_range(7, 4)) : MEM_LATENCY;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due  = due;
            r.data = mem_word(mem_addr);
            memq.push_back(r);
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data_out   = memq[0].data;
            void'(memq.pop_front());
        end else begin
            mem_data_valid = stray;
            mem_data_out   = 16'($urandom);
        end
    end

    function automatic logic [43:0] all_outs();
        return {mem_enable, mem_wr, mem_addr, mem_data_in, fill_word_idx,
                icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we,
                icache_busy, dcache_busy, dcache_wr_ack};
    endfunction

    task automatic push_fills(input logic owner, input logic [15:0] block);
        for (int k = 0; k < 8; k++) begin
            fill_t f;
            f.owner = owner;
            f.idx   = 3'(k);
            f.data  = mem_word(block + 16'(2 * k));
            fillq.push_back(f);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        icache_miss = 0; icache_miss_addr = 0;
        dcache_miss = 0; dcache_miss_addr = 0;
        dcache_wr_req = 0; dcache_wr_addr = 0; dcache_wr_data = 0;
        mem_data_valid = 0; mem_data_out = 16'h5A5A;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        vectors++;
        if (fill_data !== mem_data_out) begin
            miscompares++;
            $display("FAIL reset_fill_data: got %h expected %h", fill_data, mem_data_out);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (all_outs() !== 44'd0) begin
            miscompares++;
            $display("FAIL idle_outs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_imiss();
        int t0;
        mem_base_data = 16'hA000;
        @(negedge clk);
        t0 = cyc;
        icache_miss = 1'b1;
        icache_miss_addr = 16'h1236;
        push_fills(1'b0, 16'h1230);
        for (int k = 1; k <= 16; k++) begin
            logic        exp_en;
            logic [15:0] exp_addr;
            @(negedge clk);
            exp_en   = (k <= 8);
            exp_addr = exp_en ? 16'(16'h1230 + 2 * (k - 1)) : 16'h0000;
            vectors++;
            if ({mem_enable, mem_wr, mem_addr} !== {exp_en, 1'b0, exp_addr}) begin
                miscompares++;
                $display("FAIL imiss_req k=%0d: got en=%b wr=%b addr=%h expected en=%b wr=0 addr=%h",
                         k, mem_enable, mem_wr, mem_addr, exp_en, exp_addr);
            end
            vectors++;
            if (icache_fill_we !== (k >= 5 && k <= 12)) begin
                miscompares++;
                $display("FAIL imiss_fill_we k=%0d: got %b expected %b", k, icache_fill_we, (k >= 5 && k <= 12));
            end
            if (icache_fill_we === 1'b1 && fillq.size() > 0) begin
                fill_t f;
                f = fillq.pop_front();
                vectors++;
                if ({fill_word_idx, fill_data} !== {f.idx, f.data}) begin
                    miscompares++;
                    $display("FAIL imiss_fill_word k=%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             k, fill_word_idx, fill_data, f.idx, f.data);
                end
            end
            vectors++;
            if ({icache_tag_we, icache_busy} !== {(k == 13), (k <= 13)}) begin
                miscompares++;
                $display("FAIL imiss_tag_busy k=%0d: got tag=%b busy=%b expected tag=%b busy=%b",
                         k, icache_tag_we, icache_busy, (k == 13), (k <= 13));
            end
            vectors++;
            if ({dcache_fill_we, dcache_tag_we, dcache_busy, dcache_wr_ack} !== 4'b0) begin
                miscompares++;
                $display("FAIL imiss_dcache_quiet k=%0d: got %b expected 0000",
                         k, {dcache_fill_we, dcache_tag_we, dcache_busy, dcache_wr_ack});
            end
            if (k == 13) icache_miss = 1'b0;
        end
        vectors++;
        if (fillq.size() != 0) begin
            miscompares++;
            $display("FAIL imiss_fill_count: got %0d words missing expected 0", fillq.size());
            fillq.delete();
        end
        if (t0 < 0) $display("t0 %0d", t0);
    endtask

    task automatic test_simultaneous();
        int i_tag = -1;
        int d_tag = -1;
        int d_first = -1;
        mem_base_data = 16'h5000;
        for (int k = 0; k < 8; k++) addrq.push_back(16'(16'h0040 + 2 * k));
        for (int k = 0; k < 8; k++) addrq.push_back(16'(16'h8000 + 2 * k));
        push_fills(1'b0, 16'h0040);
        push_fills(1'b1, 16'h8000);
        @(negedge clk);
        icache_miss = 1'b1; icache_miss_addr = 16'h0040;
        dcache_miss = 1'b1; dcache_miss_addr = 16'h8000;
        for (int n = 0; n < 60 && d_tag < 0; n++) begin
            @(negedge clk);
            if (mem_enable === 1'b1) begin
                logic [15:0] ea;
                ea = (addrq.size() > 0) ? addrq.pop_front() : 16'hFFFF;
                vectors++;
                if (mem_addr !== ea) begin
                    miscompares++;
                    $display("FAIL sim_req_addr: got %h expected %h", mem_addr, ea);
                end
                if (mem_addr === 16'h8000 && d_first < 0) d_first = cyc;
            end
            if (icache_fill_we === 1'b1 || dcache_fill_we === 1'b1) begin
                fill_t f;
                f.owner = 1'b0; f.idx = 3'd0; f.data = 16'hDEAD;
                if (fillq.size() > 0) f = fillq.pop_front();
                vectors++;
                if ({dcache_fill_we, icache_fill_we, fill_word_idx, fill_data} !==
                    {f.owner, ~f.owner, f.idx, f.data}) begin
                    miscompares++;
                    $display("FAIL sim_fill: got d=%b i=%b idx=%0d data=%h expected d=%b i=%b idx=%0d data=%h",
                             dcache_fill_we, icache_fill_we, fill_word_idx, fill_data,
                             f.owner, ~f.owner, f.idx, f.data);
                end
            end
            if (icache_busy === 1'b1 && dcache_busy === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL sim_both_busy: got 11 expected one owner");
            end
            if (icache_tag_we === 1'b1) begin
                i_tag = cyc;
                icache_miss = 1'b0;
            end
            if (dcache_tag_we === 1'b1) begin
                d_tag = cyc;
                dcache_miss = 1'b0;
            end
        end
        // D is latched in the IDLE cycle after I's tag write and issues its
        // first request one cycle later.
        vectors++;
        if (i_tag < 0 || d_tag < 0 || d_first != i_tag + 2) begin
            miscompares++;
            $display("FAIL sim_order: got i_tag=%0d d_first=%0d d_tag=%0d expected d_first=i_tag+2",
                     i_tag, d_first, d_tag);
        end
        vectors++;
        if (addrq.size() != 0 || fillq.size() != 0) begin
            miscompares++;
            $display("FAIL sim_leftover: got %0d reqs %0d fills pending expected 0 0",
                     addrq.size(), fillq.size());
        end
        addrq.delete(); fillq.delete();
        dcache_miss = 1'b0; icache_miss = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_store_idle();
        @(negedge clk);
        dcache_wr_req = 1'b1; dcache_wr_addr = 16'h2000; dcache_wr_data = 16'hBEEF;
        #1;
        vectors++;
        if ({mem_enable, mem_wr, mem_addr, mem_data_in, dcache_wr_ack} !==
            {1'b1, 1'b1, 16'h2000, 16'hBEEF, 1'b1}) begin
            miscompares++;
            $display("FAIL store_idle: got en=%b wr=%b addr=%h din=%h ack=%b expected 1 1 2000 beef 1",
                     mem_enable, mem_wr, mem_addr, mem_data_in, dcache_wr_ack);
        end
        @(negedge clk);
        dcache_wr_req = 1'b0;
        #1;
        vectors++;
        if ({mem_enable, dcache_wr_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL store_release: got en=%b ack=%b expected 0 0", mem_enable, dcache_wr_ack);
        end
    endtask

    task automatic test_store_during_fill();
        int acks = 0;
        int ack_cyc = -1;
        int tag_cyc = -1;
        mem_base_data = 16'h7700;
        push_fills(1'b1, 16'h4000);
        @(negedge clk);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h4008;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 2) begin
                dcache_wr_req = 1'b1; dcache_wr_addr = 16'h2002; dcache_wr_data = 16'h1234;
                #1;
            end
            if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
                vectors++;
                if (mem_addr[15:4] !== 12'h400) begin
                    miscompares++;
                    $display("FAIL sdf_req_block: got %h expected 400x", mem_addr);
                end
            end
            if (dcache_fill_we === 1'b1) begin
                fill_t f;
                f.idx = 3'd0; f.data = 16'hDEAD; f.owner = 1'b1;
                if (fillq.size() > 0) f = fillq.pop_front();
                vectors++;
                if ({fill_word_idx, fill_data} !== {f.idx, f.data}) begin
                    miscompares++;
                    $display("FAIL sdf_fill: got idx=%0d data=%h expected idx=%0d data=%h",
                             fill_word_idx, fill_data, f.idx, f.data);
                end
            end
            if (dcache_tag_we === 1'b1) begin
                tag_cyc = cyc;
                dcache_miss = 1'b0;
            end
            if (dcache_wr_ack === 1'b1) begin
                acks++;
                ack_cyc = cyc;
                vectors++;
                if ({mem_enable, mem_wr, mem_addr, mem_data_in, dcache_busy} !==
                    {1'b1, 1'b1, 16'h2002, 16'h1234, 1'b0}) begin
                    miscompares++;
                    $display("FAIL sdf_store: got en=%b wr=%b addr=%h din=%h busy=%b expected 1 1 2002 1234 0",
                             mem_enable, mem_wr, mem_addr, mem_data_in, dcache_busy);
                end
                dcache_wr_req = 1'b0;
            end
        end
        vectors++;
        if (acks != 1 || tag_cyc < 0 || ack_cyc != tag_cyc + 1) begin
            miscompares++;
            $display("FAIL sdf_ack_timing: got acks=%0d ack=%0d tag=%0d expected 1 ack at tag+1",
                     acks, ack_cyc, tag_cyc);
        end
        vectors++;
        if (fillq.size() != 0) begin
            miscompares++;
            $display("FAIL sdf_fill_count: got %0d missing expected 0", fillq.size());
        end
        fillq.delete();
        dcache_wr_req = 1'b0; dcache_miss = 1'b0;
    endtask

    task automatic test_irregular();
        int pulses = 0;
        int tags = 0;
        int reqs = 0;
        int after = -1;
        irregular = 1'b1;
        mem_base_data = 16'hC000;
        push_fills(1'b0, 16'h5550);
        @(negedge clk);
        icache_miss = 1'b1; icache_miss_addr = 16'h5554;
        for (int n = 0; n < 80 && after != 0; n++) begin
            @(negedge clk);
            if (after > 0) after--;
            if (mem_enable === 1'b1) reqs++;
            if (icache_fill_we === 1'b1) begin
                fill_t f;
                f.idx = 3'd0; f.data = 16'hDEAD; f.owner = 1'b0;
                if (fillq.size() > 0) f = fillq.pop_front();
                pulses++;
                vectors++;
                if ({fill_word_idx, fill_data} !== {f.idx, f.data}) begin
                    miscompares++;
                    $display("FAIL irr_fill: got idx=%0d data=%h expected idx=%0d data=%h",
                             fill_word_idx, fill_data, f.idx, f.data);
                end
            end
            if (dcache_fill_we === 1'b1 || dcache_tag_we === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL irr_dcache_we: got 1 expected 0");
            end
            if (icache_tag_we === 1'b1) begin
                tags++;
                vectors++;
                if (pulses != 8) begin
                    miscompares++;
                    $display("FAIL irr_tag_early: got %0d fills before tag expected 8", pulses);
                end
                icache_miss = 1'b0;
                after = 4;
            end
        end
        vectors++;
        if (pulses != 8 || tags != 1 || reqs != 8) begin
            miscompares++;
            $display("FAIL irr_counts: got fills=%0d tags=%0d reqs=%0d expected 8 1 8", pulses, tags, reqs);
        end
        fillq.delete();
        icache_miss = 1'b0;
        irregular = 1'b0;
    endtask

    task automatic test_reset_midfill();
        int fills = 0;
        int tags = 0;
        int first_req = -1;
        mem_base_data = 16'h3300;
        @(negedge clk);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h3000;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        dcache_miss = 1'b0;
        for (int k = 7; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (all_outs() !== 44'd0) begin
                miscompares++;
                $display("FAIL rst_mid_outs k=%0d: got %h expected 0", k, all_outs());
            end
        end
        rst_n = 1'b1;
        stray = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if ({mem_enable, icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we,
                 icache_busy, dcache_busy} !== 7'd0) begin
                miscompares++;
                $display("FAIL rst_stray_ignored k=%0d: got %b expected 0000000", k,
                         {mem_enable, icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we,
                          icache_busy, dcache_busy});
            end
        end
        stray = 1'b0;
        for (int n = 0; n < 20 && memq.size() > 0; n++) @(negedge clk);
        push_fills(1'b1, 16'h3000);
        @(negedge clk);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h3006;
        for (int n = 0; n < 40 && tags == 0; n++) begin
            @(negedge clk);
            if (mem_enable === 1'b1 && first_req < 0) begin
                first_req = 1;
                vectors++;
                if (mem_addr !== 16'h3000) begin
                    miscompares++;
                    $display("FAIL refill_first_addr: got %h expected 3000", mem_addr);
                end
            end
            if (dcache_fill_we === 1'b1) begin
                fill_t f;
                f.idx = 3'd0; f.data = 16'hDEAD; f.owner = 1'b1;
                if (fillq.size() > 0) f = fillq.pop_front();
                fills++;
                vectors++;
                if ({fill_word_idx, fill_data} !== {f.idx, f.data}) begin
                    miscompares++;
                    $display("FAIL refill_word: got idx=%0d data=%h expected idx=%0d data=%h",
                             fill_word_idx, fill_data, f.idx, f.data);
                end
            end
            if (dcache_tag_we === 1'b1) begin
                tags++;
                dcache_miss = 1'b0;
            end
        end
        vectors++;
        if (fills != 8 || tags != 1) begin
            miscompares++;
            $display("FAIL refill_counts: got fills=%0d tags=%0d expected 8 1", fills, tags);
        end
        fillq.delete();
        dcache_miss = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_imiss();
        test_simultaneous();
        test_store_idle();
        test_store_during_fill();
        test_irregular();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
